// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory arbiter.
// Holds FSM state, requester and operation encodings plus width defaults.
package arb_types;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } arb_op_t;

endpackage

// File: rtl/cache_mem_arbiter_grant_select.sv
// Winner selection between the D-cache and the I-cache.
// Macro ARB_FAIR_EN: alternate on contention instead of fixed D-over-I.
module arb_grant_select
  import arb_types::*;
(
  input  logic     d_req_i,
  input  logic     i_req_i,
  input  arb_src_t last_grant_i,
  output logic     gnt_valid_o,
  output arb_src_t gnt_src_o
);

  arb_src_t both_src;

`ifdef ARB_FAIR_EN
  // on contention hand the port to whoever did not have it last
  assign both_src = (last_grant_i == SRC_D) ? SRC_I : SRC_D;
`else
  logic unused_last;

  assign unused_last = last_grant_i;
  // D-cache misses stall the whole pipeline, so D always wins
  assign both_src    = SRC_D;
`endif

  // pick the single winner from the pending requests
  always_comb begin
    gnt_valid_o = d_req_i | i_req_i;
    gnt_src_o   = SRC_I;
    unique case (1'b1)
      (d_req_i && i_req_i):  gnt_src_o = both_src;
      (d_req_i && !i_req_i): gnt_src_o = SRC_D;
      default:               gnt_src_o = SRC_I;
    endcase
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between I-cache and D-cache.
// Macro ARB_FAIR_EN enables alternating grants on contention.
module cache_mem_arbiter
  import arb_types::*;
#(
  parameter int ADDR_W   = arb_types::ADDR_W,
  parameter int LINE_W   = arb_types::LINE_W,
  parameter int OFFSET_W = arb_types::OFFSET_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q, state_d;
  arb_src_t          last_q, last_d;
  arb_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic              d_req;
  logic              gnt_valid;
  arb_src_t          gnt_src;

  assign d_req = d_read | d_write;

  arb_grant_select u_sel (
    .d_req_i      (d_req),
    .i_req_i      (i_read),
    .last_grant_i (last_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_src_o    (gnt_src)
  );

  // next state, request latching and response gating
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          if (gnt_src == SRC_D) begin
            state_d = ARB_SERVE_D;
            addr_d  = {d_address[ADDR_W-1:OFFSET_W],
                       {OFFSET_W{1'b0}}};
            wdata_d = d_wdata;
            op_d    = d_write ? OP_WRITE : OP_READ;
          end else begin
            state_d = ARB_SERVE_I;
            addr_d  = {i_address[ADDR_W-1:OFFSET_W],
                       {OFFSET_W{1'b0}}};
            op_d    = OP_READ;
          end
        end
      end
      ARB_SERVE_I: begin
        if (mem_resp) begin
          i_resp  = 1'b1;
          state_d = ARB_IDLE;
          last_d  = SRC_I;
        end
      end
      ARB_SERVE_D: begin
        if (mem_resp) begin
          d_resp  = 1'b1;
          state_d = ARB_IDLE;
          last_d  = SRC_D;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // state and latched transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_q  <= SRC_I;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // strobes come only from registers so they never glitch
  assign mem_read    = (state_q != ARB_IDLE) && (op_q == OP_READ);
  assign mem_write   = (state_q != ARB_IDLE) && (op_q == OP_WRITE);
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory port between the I-cache miss path and the D-cache miss/writeback path of the pipelined CPU.
- Uses a small FSM to grant one whole-line transaction at a time.
- Latches the winner's address, data and operation, drives the memory, and returns the response only to the granted cache.
- Sits between the two caches and the memory model or L2.

Parameters:
ADDR_W, 32, byte-address width.
LINE_W, 256, cache-line width in bits.
OFFSET_W, 5, line-offset bits (log2(LINE_W/8)); these bits are forced to zero on mem_address.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
i_read  in  1  I-cache line-fill request; held until i_resp.
i_address  in  ADDR_W  I-cache line address.
i_rdata  out  LINE_W  fill data, valid when i_resp=1.
i_resp  out  1  one-cycle completion to the I-cache.
d_read  in  1  D-cache line-fill request; held until d_resp.
d_write  in  1  D-cache writeback request; held until d_resp.
d_address  in  ADDR_W  D-cache line address.
d_wdata  in  LINE_W  writeback data.
d_rdata  out  LINE_W  fill data, valid when d_resp=1.
d_resp  out  1  one-cycle completion to the D-cache.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
mem_address  out  ADDR_W  line-aligned memory address.
mem_wdata  out  LINE_W  memory write data.
mem_rdata  in  LINE_W  memory read data.
mem_resp  in  1  memory completion, one cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all strobes and resps are 0.
  - mem_address, mem_wdata and the latched op registers are 0; last_grant=I.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - d_req = d_read|d_write.
  - If d_req, go to SERVE_D; else if i_read, go to SERVE_I; else stay.
  - Default is fixed priority, D over I. D-cache misses stall the whole pipeline, so D wins.
  - On the transition edge, latch mem_address={addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0}, mem_wdata=d_wdata (D only) and op.
  - Op is write if d_write, else read. If d_read and d_write are both 1, write wins.
  - No memory strobe is driven in IDLE.
- SERVE_x:
  - mem_read = latched op is read; mem_write = latched op is write.
  - Strobes come from registered state, so they are glitch-free.
  - Latched address and data stay stable until mem_resp, regardless of requester inputs.
  - On mem_resp=1, in the same cycle:
    - x_resp=1.
    - x_rdata=mem_rdata (pass-through, combinational).
    - Next state is IDLE; last_grant=x.
  - mem_resp never produces a resp to the non-granted cache.
  - i_rdata and d_rdata are mem_rdata at all times; only the resps are gated.
- Latency and spacing:
  - mem strobe rises 1 cycle after the request is seen in IDLE.
  - Requester completion arrives in the same cycle as mem_resp.
  - At least one IDLE cycle separates consecutive transactions, so strobes are low for ≥1 cycle between them.
- Requester rule:
  - A cache deasserts its request in the cycle after its resp.
  - A request still high in IDLE after a resp is treated as a new transaction.
- mem_resp arriving in IDLE is ignored; no state change, no resp.
- A requester dropping its request mid-SERVE does not abort the transaction. The transaction completes to memory and the resp is still pulsed.
- Reset mid-transaction returns to IDLE immediately and strobes drop. Memory-side cleanup is the environment's responsibility.

Optional Feature:
- Macro ARB_FAIR_EN.
- Defined:
  - In IDLE with both d_req and i_read pending, grant the cache that was NOT last_grant (alternating).
  - A single pending requester is granted as normal.
  - Guarantees the I-cache waits at most one D transaction.
- Undefined: fixed D-over-I priority; last_grant logic may be optimised away.

Decomposition:
- Package arb_types holds:
  - arb_state_t enum {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}.
  - arb_src_t enum {SRC_I, SRC_D}.
  - arb_op_t enum {OP_READ, OP_WRITE}.
  - Localparams LINE_W and OFFSET_W defaults.
- One sub-module, arb_grant_select: combinational winner selection from d_req, i_read and last_grant, with the ARB_FAIR_EN variant.
- The FSM and latches stay in cache_mem_arbiter.

Test Plan:
1. Reset: rst_n=0 with d_read=1 held → all strobes and resps 0, mem_address=0. Release rst_n → mem_read=1 on the next cycle with the D address.
2. Solo I fill: i_read=1, i_address=0x0000_1234, memory responds after 5 cycles with line 0xA5.. → mem_address=0x0000_1220, mem_read=1 for 5 cycles, i_resp=1 for 1 cycle, i_rdata=0xA5.., d_resp stays 0.
3. Writeback then fill: d_write=1, d_address=0x8000_0040, d_wdata=0xDEAD.. → mem_write=1, mem_wdata=0xDEAD.., d_resp pulse, ≥1 idle cycle. Then d_read at 0x8000_0060 → mem_read with the new address.
4. Contention: i_read and d_read raised in the same cycle → without ARB_FAIR_EN, D is served first, then I. With ARB_FAIR_EN, D is served first and I next even if D re-requests immediately; a second simultaneous round goes to D only after the I grant.
5. Illegal D op and drop: d_read=d_write=1 → a write is issued. i_read dropped mid-SERVE_I → the transaction completes and i_resp still pulses.
6. Stray mem_resp in IDLE, and rst_n asserted mid-SERVE_D → no resp pulses; state is IDLE and strobes drop asynchronously.
